fft16_sequencer: RTL
====================

// Module: fft16_sequencer
// PURPOSE
// - Control/buffer stage wrapped around the radix-4 butterfly for the 16-point FFT.
// - Collects 16 complex samples from a valid/ready stream and issues four stage-1 words (rotation 0..3).
// - Captures the butterfly results, re-issues them as four stage-2 words (rotation 4..7).
// - Captures the final bins and streams X[0]..X[15] out in natural order with backpressure.
// PARAMETERS
// - BF_LAT  1   butterfly latency in cycles: word on bf_calc_in in cycle c appears on bf_calc_out in cycle c+BF_LAT; range 1..4
// - DW      17  component width: two's complement, sign + 8 integer + 8 fraction bits
// PORTS
// - clk          in   1    single clock; all state updates on the rising edge
// - rst          in   1    synchronous, active-high reset
// - in_valid     in   1    input sample valid
// - in_ready     out  1    high only in LOAD
// - in_re        in   DW   sample real part
// - in_im        in   DW   sample imaginary part
// - bf_calc_in   out  136  butterfly operand word, registered
// - bf_rotation  out  3    butterfly rotation code, registered
// - bf_calc_out  in   136  butterfly result word
// - out_valid    out  1    output bin valid
// - out_ready    in   1    downstream accepts the bin
// - out_re       out  DW   bin real part
// - out_im       out  DW   bin imaginary part
// - out_idx      out  4    bin index m of X[m]
// - busy         out  1    high in every state except LOAD
// BEHAVIOUR
// - Word packing: lane j (0..3) occupies bits [34j+33:34j] as {Re[16:0],Im[16:0]}; lane 0 is the lowest lane.
// - Reset (synchronous, active-high) takes effect at any point, including mid-frame:
//   - State goes to LOAD; the sample counter and all pipeline tags are cleared; the frame in progress is discarded.
//   - Output values: in_ready=1, busy=0, out_valid=0, out_re=0, out_im=0, out_idx=0, bf_calc_in=0, bf_rotation=0.
// - FSM: LOAD -> S1_ISSUE -> S1_DRAIN -> S2_ISSUE -> S2_DRAIN -> OUT -> LOAD.
// - LOAD:
//   - A sample is accepted on each cycle with in_valid & in_ready. Gaps in in_valid are allowed.
//   - Sample n (0..15) is stored in word n/4, lane n%4.
//   - After sample 15 is accepted, in_ready drops on the next cycle and the FSM moves to S1_ISSUE.
// - S1_ISSUE:
//   - Drives word k (k=0..3) on bf_calc_in with bf_rotation=k in four consecutive cycles.
// - S1_DRAIN:
//   - bf_calc_out is sampled exactly BF_LAT cycles after word k was driven and stored in s1_buf[k].
//   - A BF_LAT-deep tag shift register (valid, stage, k) sets the capture timing.
//   - The FSM leaves the state on the cycle after capture 3.
// - S2_ISSUE:
//   - Drives s1_buf[k] unmodified with bf_rotation=4+k in four consecutive cycles.
// - S2_DRAIN capture mapping for word k:
//   - lane 3 -> X[k]
//   - lane 2 -> X[k+4]
//   - lane 1 -> X[k+8]
//   - lane 0 -> X[k+12]
// - bf_calc_in and bf_rotation return to 0 in every cycle with no issue.
// - OUT:
//   - out_valid=1 with m = 0..15 in order.
//   - m advances only on out_valid & out_ready; out_re, out_im and out_idx hold stable while out_ready=0.
//   - The handshake of m=15 deasserts out_valid and returns the FSM to LOAD; in_ready is high the following cycle.
// - Timing:
//   - Last sample accepted in cycle t -> first S1 issue in t+1.
//   - First out_valid in t+12+2*BF_LAT; for BF_LAT=1 that is t+14.
// - No arithmetic in this block. Data is passed bit-exact; no saturation, rounding or sign handling.
// - in_valid outside LOAD is ignored. bf_calc_out outside capture cycles is ignored.
// - Frames do not overlap: a new frame loads only after all 16 bins are delivered.
// TESTING
// - Bench uses an identity butterfly stub delayed by BF_LAT; run with BF_LAT=1 and BF_LAT=3.
// - Ramp frame (in_re=n, in_im=-n, n=0..15, in_valid always high, out_ready=1):
//   - S1 bf_rotation sequence = 0,1,2,3; S2 sequence = 4,5,6,7.
//   - word0 lane0 Re = 17'h00000; word0 lane3 Re = 17'h00003.
//   - out_re order = 3,7,11,15,2,6,10,14,1,5,9,13,0,4,8,12; out_idx = 0..15; out_im = -out_re.
// - Impulse frame (sample 0 = 17'h00100 + j0, rest 0):
//   - X[12] = 17'h00100; all other bins = 0.
//   - First out_valid lands exactly 14 cycles after the last accept (BF_LAT=1).
// - Backpressure (out_ready toggling 1,0,0,1...):
//   - No bin lost or duplicated; outputs are stable while stalled.
//   - in_ready stays 0 until bin 15 is accepted.
// - Input gaps (in_valid low every other cycle) and in_valid high during S1..OUT:
//   - Identical output to the ramp frame.
//   - Extra samples are not consumed.
// - Reset asserted one cycle mid-S2_ISSUE, then a fresh ramp frame:
//   - All outputs are at reset values the cycle after reset.
//   - Fresh frame output matches the ramp result exactly.
// - Back-to-back frames (ramp, then ramp+16):
//   - Second frame bins are offset by 16.
//   - No data from frame 1 leaks into frame 2.

Source files
------------

// File: rtl/fft16_sequencer.sv
// Control and buffer stage around the radix-4 butterfly of a 16-point FFT:
// loads 16 samples, runs two butterfly passes, then streams X[0..15] in order.
module fft16_sequencer #(
   parameter int BF_LAT = 1,
   parameter int DW     = 17
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_re,
   input  logic [DW-1:0]   in_im,
   output logic [8*DW-1:0] bf_calc_in,
   output logic [2:0]      bf_rotation,
   input  logic [8*DW-1:0] bf_calc_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_re,
   output logic [DW-1:0]   out_im,
   output logic [3:0]      out_idx,
   output logic            busy
);
   localparam int LW = 2 * DW;
   localparam int WW = 4 * LW;

   typedef enum logic [2:0] {
      LOAD,
      S1_ISSUE,
      S1_DRAIN,
      S2_ISSUE,
      S2_DRAIN,
      OUT
   } state_t;

   state_t state_reg, state_next;
   logic [3:0] cnt_reg;
   logic [1:0] k_reg, k_next;
   logic       done_reg;
   logic       issue_next, issue_s2_next;
   logic       in_accept;
   logic       last_handshake;

   logic [LW-1:0]      samp_mem [16];
   logic [WW-1:0]      s1_buf [4];
   logic [LW-1:0]      bin_mem [16];
   logic [16*LW-1:0]   samp_flat;
   logic [WW-1:0]      issue_word;

   logic [BF_LAT:0]      tag_valid, tag_s2;
   logic [BF_LAT:0][1:0] tag_k;
   logic                 cap, cap_s2, cap3;
   logic [1:0]           cap_k;

   logic [WW-1:0] bf_calc_in_reg;
   logic [2:0]    bf_rotation_reg;
   logic          out_valid_reg;
   logic [LW-1:0] out_data_reg;
   logic [3:0]    out_idx_reg;
   logic [4:0]    rd_ptr_reg;

   assign in_ready       = (state_reg == LOAD);
   assign busy           = (state_reg != LOAD);
   assign in_accept      = (state_reg == LOAD) && in_valid;
   assign last_handshake = out_valid_reg && out_ready && (out_idx_reg == 4'd15);

   // Sample n lands in word n/4, lane n%4: a flat view makes word k a plain slice.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_flat
         assign samp_flat[gi*LW +: LW] = samp_mem[gi];
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      k_next        = k_reg;
      issue_next    = 1'b0;
      issue_s2_next = 1'b0;
      unique case (state_reg)
         LOAD: begin
            if (in_accept && cnt_reg == 4'd15) begin
               state_next = S1_ISSUE;
               k_next     = 2'd0;
               issue_next = 1'b1;
            end
         end
         S1_ISSUE: begin
            if (k_reg == 2'd3) begin
               state_next = S1_DRAIN;
            end else begin
               k_next     = k_reg + 2'd1;
               issue_next = 1'b1;
            end
         end
         S1_DRAIN: begin
            if (done_reg) begin
               state_next    = S2_ISSUE;
               k_next        = 2'd0;
               issue_next    = 1'b1;
               issue_s2_next = 1'b1;
            end
         end
         S2_ISSUE: begin
            if (k_reg == 2'd3) begin
               state_next = S2_DRAIN;
            end else begin
               k_next        = k_reg + 2'd1;
               issue_next    = 1'b1;
               issue_s2_next = 1'b1;
            end
         end
         S2_DRAIN: begin
            if (done_reg) state_next = OUT;
         end
         OUT: begin
            if (last_handshake) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   assign issue_word = issue_s2_next ? s1_buf[k_next] : samp_flat[int'(k_next)*WW +: WW];

   // Tag slot 0 travels with the word on bf_calc_in; slot BF_LAT marks its result.
   assign cap    = tag_valid[BF_LAT];
   assign cap_s2 = tag_s2[BF_LAT];
   assign cap_k  = tag_k[BF_LAT];
   assign cap3   = cap && (cap_k == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= LOAD;
         cnt_reg         <= '0;
         k_reg           <= '0;
         done_reg        <= 1'b0;
         tag_valid       <= '0;
         tag_s2          <= '0;
         tag_k           <= '0;
         bf_calc_in_reg  <= '0;
         bf_rotation_reg <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         if (in_accept) cnt_reg <= cnt_reg + 4'd1;
         tag_valid <= {tag_valid[BF_LAT-1:0], issue_next};
         tag_s2    <= {tag_s2[BF_LAT-1:0], issue_s2_next};
         tag_k     <= {tag_k[BF_LAT-1:0], k_next};
         bf_calc_in_reg  <= issue_next ? issue_word : '0;
         bf_rotation_reg <= issue_next ? {issue_s2_next, k_next} : 3'd0;
         // Drain states leave one cycle after the last result has been captured.
         if (cap3)
            done_reg <= 1'b1;
         else if ((state_reg == S1_DRAIN || state_reg == S2_DRAIN) && done_reg)
            done_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (in_accept) samp_mem[cnt_reg] <= {in_re, in_im};
   end

   always_ff @(posedge clk) begin
      if (cap && !cap_s2) s1_buf[cap_k] <= bf_calc_out;
   end

   // Stage-2 lane j of word k holds bin k + 4*(3-j).
   always_ff @(posedge clk) begin
      if (cap && cap_s2) begin
         for (int j = 0; j < 4; j++) begin
            bin_mem[{2'(3 - j), cap_k}] <= bf_calc_out[j*LW +: LW];
         end
      end
   end

   // Registered read of the bin store; the first OUT cycle prefetches bin 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_idx_reg   <= '0;
         rd_ptr_reg    <= '0;
      end else if (state_reg == OUT) begin
         if (last_handshake) begin
            out_valid_reg <= 1'b0;
            rd_ptr_reg    <= '0;
         end else if ((!out_valid_reg || out_ready) && !rd_ptr_reg[4]) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= bin_mem[rd_ptr_reg[3:0]];
            out_idx_reg   <= rd_ptr_reg[3:0];
            rd_ptr_reg    <= rd_ptr_reg + 5'd1;
         end
      end
   end

   assign bf_calc_in  = bf_calc_in_reg;
   assign bf_rotation = bf_rotation_reg;
   assign out_valid   = out_valid_reg;
   assign out_re      = out_data_reg[LW-1:DW];
   assign out_im      = out_data_reg[DW-1:0];
   assign out_idx     = out_idx_reg;

endmodule
